// File: rtl/avalon_pio_in_pkg.sv
// avalon_pio_in_pkg: register map and shared helpers for the debounced input PIO.
`default_nettype none

package avalon_pio_in_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RAW  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_RISE = 3'd4;
    localparam logic [2:0] ADDR_FALL = 3'd5;

    // Set-dominant W1C update: a new edge survives a clear landing on the same cycle.
    function automatic logic [31:0] w1c_set_wins(input logic [31:0] cur,
                                                  input logic [31:0] clr,
                                                  input logic [31:0] set);
        return (cur & ~clr) | set;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pio_in_debounce_ch.sv
// pio_in_debounce_ch: one input channel - synchroniser, stability counter and edge flops.
`default_nettype none

module pio_in_debounce_ch
    import avalon_pio_in_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic sync_o,
    output logic stable_o,
    output logic rise_raw_o,
    output logic fall_raw_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stable_d1_q;
    logic                   w_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign w_stable = sync_o;
        end else begin : g_dbnc
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             stable_q, stable_d;

            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync_o == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = sync_o;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign w_stable = stable_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d1_q <= 1'b0;
        end else begin
            stable_d1_q <= w_stable;
        end
    end

    assign stable_o   = w_stable;
    assign rise_raw_o = w_stable & ~stable_d1_q;
    assign fall_raw_o = ~w_stable & stable_d1_q;

endmodule

`default_nettype wire

// File: rtl/avalon_pio_in_dbnc.sv
// avalon_pio_in_dbnc: Avalon-MM input PIO with per-channel debounce, edge capture and irq.
`default_nettype none

module avalon_pio_in_dbnc
    import avalon_pio_in_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync, w_stable, w_rise_raw, w_fall_raw;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] w_wdata, w_clr, w_set;
    logic             w_we;
    logic             w_unused_wd;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            pio_in_debounce_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .din_i     (in_port[i]),
                .sync_o    (w_sync[i]),
                .stable_o  (w_stable[i]),
                .rise_raw_o(w_rise_raw[i]),
                .fall_raw_o(w_fall_raw[i])
            );
        end
    endgenerate

    assign w_we        = chipselect & ~write_n;
    assign w_wdata     = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;
    assign w_set       = (w_rise_raw & rise_en_q) | (w_fall_raw & fall_en_q);
    assign w_clr       = (w_we && address == ADDR_EDGE) ? w_wdata : '0;

    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        edge_d    = WIDTH'(w1c_set_wins(32'(edge_q), 32'(w_clr), 32'(w_set)));
        if (w_we) begin
            case (address)
                ADDR_MASK: mask_d    = w_wdata;
                ADDR_RISE: rise_en_d = w_wdata;
                ADDR_FALL: fall_en_d = w_wdata;
                default:   ;
            endcase
        end
    end

    // Read path is unqualified by chipselect: the bridge samples it one cycle later.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(w_stable);
            ADDR_RAW:  readdata_d = 32'(w_sync);
            ADDR_MASK: readdata_d = 32'(mask_q);
            ADDR_EDGE: readdata_d = 32'(edge_q);
            ADDR_RISE: readdata_d = 32'(rise_en_q);
            ADDR_FALL: readdata_d = 32'(fall_en_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q     <= '0;
            edge_q     <= '0;
            rise_en_q  <= '1;
            fall_en_q  <= '1;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

`default_nettype wire

// File: tb/tb_avalon_pio_in_dbnc.sv
// tb_avalon_pio_in_dbnc: directed, table-driven bench for the debounced input PIO.
`default_nettype none

module tb_avalon_pio_in_dbnc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  in_port = '0;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    avalon_pio_in_dbnc #(
        .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(posedge clk);
        @(negedge clk);
        d = readdata;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic [31:0] d;

        vecs[0]  = '{1'b0, 3'd0, 32'h0, 32'h000};
        vecs[1]  = '{1'b0, 3'd1, 32'h0, 32'h000};
        vecs[2]  = '{1'b0, 3'd2, 32'h0, 32'h000};
        vecs[3]  = '{1'b0, 3'd3, 32'h0, 32'h000};
        vecs[4]  = '{1'b0, 3'd4, 32'h0, 32'h3FF};
        vecs[5]  = '{1'b0, 3'd5, 32'h0, 32'h3FF};
        vecs[6]  = '{1'b0, 3'd6, 32'h0, 32'h000};
        vecs[7]  = '{1'b0, 3'd7, 32'h0, 32'h000};
        vecs[8]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h3FF};
        vecs[9]  = '{1'b1, 3'd2, 32'h0, 32'h000};
        vecs[10] = '{1'b1, 3'd4, 32'h0AA, 32'h0AA};
        vecs[11] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 32'h3FF};
        vecs[12] = '{1'b1, 3'd0, 32'h3FF, 32'h000};
        vecs[13] = '{1'b1, 3'd1, 32'h3FF, 32'h000};
        vecs[14] = '{1'b1, 3'd6, 32'hFFFF, 32'h000};
        vecs[15] = '{1'b1, 3'd5, 32'h155, 32'h155};
        vecs[16] = '{1'b1, 3'd5, 32'h3FF, 32'h3FF};
        vecs[17] = '{1'b1, 3'd3, 32'h3FF, 32'h000};

        // Reset and register map
        cycles(3);
        @(negedge clk) reset = 1'b0;
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_readdata", readdata, 32'h0);
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, d);
            chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
        end

        // Debounce: 3-cycle glitch rejected
        wr(3'd2, 32'h001);
        @(negedge clk) in_port[0] = 1'b1;
        cycles(3);
        #1 in_port[0] = 1'b0;
        cycles(15);
        rd(3'd3, d);
        chk("glitch_edge", d, 32'h0);
        rd(3'd0, d);
        chk("glitch_data", d, 32'h0);
        chk("glitch_irq", 32'(irq), 32'h0);

        // Debounce: stable step, DATA after edge 6 (visible on readdata after 7), capture at 7
        @(negedge clk) begin in_port[0] = 1'b1; address = 3'd0; end
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 6) begin
                chk("step_data_e6", readdata, 32'h0);
                chk("step_irq_e6", 32'(irq), 32'h0);
            end
            if (k == 7) begin
                chk("step_data_e7", readdata, 32'h1);
                chk("step_irq_e7", 32'(irq), 32'h1);
            end
        end
        rd(3'd3, d);
        chk("step_edge", d, 32'h001);
        rd(3'd1, d);
        chk("step_raw", d, 32'h001);

        // RAW latency on the falling step
        @(negedge clk) begin in_port[0] = 1'b0; address = 3'd1; end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 2) chk("raw_e2", readdata, 32'h1);
            if (k == 3) chk("raw_e3", readdata, 32'h0);
        end
        cycles(10);
        wr(3'd3, 32'h001);
        rd(3'd3, d);
        chk("clr_bit0", d, 32'h0);
        wr(3'd2, 32'h0);

        // Edge select: only falling edge of bit 2
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h004);
        @(negedge clk) in_port[2] = 1'b1;
        cycles(20);
        rd(3'd3, d);
        chk("sel_rise_ignored", d, 32'h0);
        @(negedge clk) in_port[2] = 1'b0;
        cycles(20);
        rd(3'd3, d);
        chk("sel_fall_captured", d, 32'h004);
        wr(3'd3, 32'h004);
        wr(3'd4, 32'h3FF);
        wr(3'd5, 32'h3FF);
        rd(3'd3, d);
        chk("sel_cleared", d, 32'h0);

        // Interrupt and W1C release
        wr(3'd2, 32'h002);
        @(negedge clk) in_port[1] = 1'b1;
        cycles(12);
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'h1);
        wr(3'd3, 32'h002);
        @(negedge clk);
        chk("irq_after_w1c", 32'(irq), 32'h0);
        rd(3'd3, d);
        chk("edge_after_w1c", d, 32'h0);

        // Mask applied after capture raises irq right after the write edge
        wr(3'd2, 32'h0);
        @(negedge clk) in_port[1] = 1'b0;
        cycles(12);
        @(negedge clk);
        chk("masked_irq", 32'(irq), 32'h0);
        wr(3'd2, 32'h002);
        @(negedge clk);
        chk("unmask_irq", 32'(irq), 32'h1);
        wr(3'd3, 32'h002);
        wr(3'd2, 32'h0);

        // Simultaneous clear and set on bit 3: set wins
        @(negedge clk) in_port[3] = 1'b1;
        cycles(6);
        @(negedge clk);
        address = 3'd3; writedata = 32'h008; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1;
        rd(3'd3, d);
        chk("set_wins", d, 32'h008);
        wr(3'd3, 32'h008);
        rd(3'd3, d);
        chk("set_wins_clear", d, 32'h0);

        // Reset while bit 5 is mid-count
        wr(3'd2, 32'h020);
        wr(3'd5, 32'h2AA);
        @(negedge clk) in_port[5] = 1'b1;
        cycles(4);
        #1 begin reset = 1'b1; in_port = '0; end
        cycles(2);
        @(negedge clk) reset = 1'b0;
        cycles(15);
        rd(3'd0, d); chk("rst_data", d, 32'h0);
        rd(3'd1, d); chk("rst_raw", d, 32'h0);
        rd(3'd2, d); chk("rst_mask", d, 32'h0);
        rd(3'd3, d); chk("rst_edge", d, 32'h0);
        rd(3'd4, d); chk("rst_rise", d, 32'h3FF);
        rd(3'd5, d); chk("rst_fall", d, 32'h3FF);
        chk("rst_irq", 32'(irq), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/avalon_pio_in_dbnc.md
# avalon_pio_in_dbnc

Parametrised Avalon-MM input PIO for board switches and push-buttons. It synchronises and debounces a configurable number of input channels. It detects rising and/or falling edges per channel, latches them in a write-1-to-clear capture register, and raises a maskable level interrupt to the HPS/Nios interrupt controller. It replaces fixed-width any-edge switch PIOs in the QSYS system and sits directly on the lightweight bridge.

## Interface
- WIDTH, 10: number of input channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per channel, 2..4.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced value changes; 0 bypasses the debouncer.
- CNT_W, 16: debounce counter width; DEBOUNCE_CYCLES < 2^CNT_W.

Ports:
- clk  in  1: single system clock.
- reset  in  1: asynchronous, active-high reset.
- address  in  3: word address.
- chipselect  in  1: slave select.
- write_n  in  1: active-low write strobe, qualified by chipselect.
- writedata  in  32: write data.
- readdata  out  32: registered read data.
- in_port  in  WIDTH: raw asynchronous inputs.
- irq  out  1: level interrupt.

## Operation
- Register map (bits above WIDTH read 0, writes ignored):
  - 0 DATA (RO): debounced value.
  - 1 RAW (RO): synchronised, undebounced value.
  - 2 IRQ_MASK (RW).
  - 3 EDGE_CAPTURE (R/W1C).
  - 4 RISE_EN (RW).
  - 5 FALL_EN (RW).
  - 6–7 read 0.
- Reads: readdata is loaded every cycle from the address mux, regardless of chipselect.
- Writes: take effect when chipselect=1 and write_n=0. Writes to RO or unused addresses are ignored.
- Synchroniser: an SYNC_STAGES-deep flop chain per channel produces sync[i].
- Debouncer, per channel:
  - States: stable[i] and cnt[i].
  - If sync[i]==stable[i], cnt is cleared to 0.
  - Otherwise cnt increments. When cnt==DEBOUNCE_CYCLES-1, stable[i] takes sync[i] and cnt is cleared.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
  - With DEBOUNCE_CYCLES=0, stable = sync.
- Edge detect:
  - stable_d1 is a one-cycle delay of stable.
  - rise = stable & ~stable_d1 & RISE_EN.
  - fall = ~stable & stable_d1 & FALL_EN.
- EDGE_CAPTURE[i]:
  - Set by rise[i] | fall[i].
  - Cleared by writing 1 to bit i; writing 0 leaves the bit unchanged.
  - If a clear and a new edge hit the same bit in the same cycle, set wins, so no edge is lost.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers, glitch-free.
- Reset values:
  - readdata = 0, IRQ_MASK = 0, EDGE_CAPTURE = 0.
  - RISE_EN = all 1s, FALL_EN = all 1s, matching the any-edge behaviour of the existing switch PIO.
  - Synchroniser flops, stable and stable_d1 = 0; counters = 0; irq = 0.
  - Inputs held high through reset therefore produce one rising capture after release. Software clears EDGE_CAPTURE before unmasking.
- Reset asserted mid-debounce abandons the count; nothing is captured.

## Timing
- Read latency is 1 cycle: address is presented at edge N and readdata is valid after edge N+1. There are no wait states.
- A write lands on the clock edge where it is presented. A read at the next cycle returns the new value.
- Input-to-capture latency = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles. With defaults, an in_port step sampled at edge 1 gives:
  - sync changes at edge 2;
  - DATA changes at edge 6;
  - EDGE_CAPTURE bit set and irq high after edge 7.
- irq deasserts in the cycle after the W1C write edge, unless the simultaneous-set rule applies.
- IRQ_MASK changes affect irq combinationally after the write edge.

## Structure
- Package avalon_pio_in_pkg holds the address constants:
  - ADDR_DATA=0, ADDR_RAW=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_RISE=4, ADDR_FALL=5.
- Sub-module pio_in_debounce_ch contains one channel: synchroniser, counter, stable and stable_d1. Parameters SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W. Outputs sync, stable, rise_raw, fall_raw.
- The top level generates WIDTH instances and owns the register file, read mux and irq.

## Test plan
- Reset/defaults: reset 3 cycles with in_port=0 → all reads 0 except RISE_EN=FALL_EN=0x3FF; irq=0.
- Debounce: bit 0 pulses high for 3 cycles, then high for 10 → no capture on the pulse; DATA=0x001 exactly 6 cycles after the stable high is sampled; EDGE_CAPTURE=0x001 one cycle later. RAW follows after 2 cycles.
- Edge select: RISE_EN=0, FALL_EN=0x004; bit 2 goes 0→1→0 with 20 cycles between edges → only the falling edge sets EDGE_CAPTURE=0x004.
- Interrupt: IRQ_MASK=0x002, bit 1 rises → irq=1. Write 0x002 to addr 3 → irq=0 next cycle; EDGE_CAPTURE=0.
- Simultaneous clear and set: time a W1C of bit 3 on the same edge bit 3's capture fires → EDGE_CAPTURE[3] stays 1.
- Reset mid-operation: assert reset while bit 5's counter=2 → all state 0. After release with in_port[5] held 0, no capture occurs.
